// File: rtl/alarm_unit.sv
// rtl/alarm_unit.sv - BCD alarm time register, match detect and ring/snooze FSM
// driving a cadence-gated buzzer tone.
module alarm_unit #(
   parameter int RING_SECS  = 60,
   parameter int SNOOZE_MIN = 5,
   parameter int TONE_DIV   = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sec_pulse,
   input  logic [23:0] time_bcd,
   input  logic        set_mode,
   input  logic [3:0]  btn,
   output logic [15:0] alarm_bcd,
   output logic        armed,
   output logic [1:0]  state,
   output logic        ringing,
   output logic        buzzer
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RING   = 2'b01,
      S_SNOOZE = 2'b10
   } state_t;

   localparam int              TW            = $clog2(TONE_DIV + 1);
   localparam logic [7:0]      LP_RING_END   = 8'(RING_SECS);
   localparam logic [11:0]     LP_SNOOZE_END = 12'(SNOOZE_MIN * 60);
   localparam logic [TW-1:0]   LP_TONE_LAST  = TW'(TONE_DIV - 1);

   state_t          r_state;
   logic [7:0]      r_hh;
   logic [7:0]      r_mm;
   logic            r_armed;
   logic [7:0]      r_ring_cnt;
   logic [11:0]     r_snooze_cnt;
   logic [TW-1:0]   r_tone_cnt;
   logic            r_phase;
   logic            r_ringing;
   logic            r_buzzer;

   logic            w_match;
   logic [7:0]      w_ring_inc;
   logic [11:0]     w_snooze_inc;
   logic            w_tone_wrap;
   logic [TW-1:0]   w_tone_nx;
   logic            w_phase_nx;

   function automatic logic [7:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] last);
      if (v == last)
         return 8'h00;
      else if (v[3:0] == 4'd9)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign w_match = sec_pulse && r_armed && !set_mode && (r_state == S_IDLE) &&
                    (time_bcd[23:8] == {r_hh, r_mm}) && (time_bcd[7:0] == 8'h00);
   assign w_ring_inc   = r_ring_cnt + 8'd1;
   assign w_snooze_inc = r_snooze_cnt + 12'd1;
   assign w_tone_wrap  = (r_tone_cnt == LP_TONE_LAST);
   assign w_tone_nx    = w_tone_wrap ? '0 : r_tone_cnt + TW'(1);
   assign w_phase_nx   = r_phase ^ w_tone_wrap;

   // Buzzer is registered from next-cycle values so the gate follows ring_cnt[0] without lag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_hh         <= 8'h07;
         r_mm         <= 8'h00;
         r_armed      <= 1'b0;
         r_ring_cnt   <= '0;
         r_snooze_cnt <= '0;
         r_tone_cnt   <= '0;
         r_phase      <= 1'b0;
         r_ringing    <= 1'b0;
         r_buzzer     <= 1'b0;
      end else begin
         if (set_mode) begin
            if (btn[0]) r_hh <= f_bcd_inc(r_hh, 8'h23);
            if (btn[1]) r_mm <= f_bcd_inc(r_mm, 8'h59);
         end
         if (r_state == S_IDLE && btn[3])
            r_armed <= ~r_armed;

         r_tone_cnt <= '0;
         r_phase    <= 1'b0;
         r_buzzer   <= 1'b0;

         if (set_mode) begin
            r_state   <= S_IDLE;
            r_ringing <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (!btn[3] && w_match) begin
                     r_state    <= S_RING;
                     r_ringing  <= 1'b1;
                     r_ring_cnt <= '0;
                  end
               end
               S_RING: begin
                  if (btn[3]) begin
                     r_state   <= S_IDLE;
                     r_ringing <= 1'b0;
                  end else if (btn[2]) begin
                     r_state      <= S_SNOOZE;
                     r_ringing    <= 1'b0;
                     r_snooze_cnt <= '0;
                  end else if (sec_pulse && w_ring_inc == LP_RING_END) begin
                     r_state    <= S_IDLE;
                     r_ringing  <= 1'b0;
                     r_ring_cnt <= w_ring_inc;
                  end else begin
                     r_tone_cnt <= w_tone_nx;
                     r_phase    <= w_phase_nx;
                     if (sec_pulse) begin
                        r_ring_cnt <= w_ring_inc;
                        r_buzzer   <= w_phase_nx & ~w_ring_inc[0];
                     end else begin
                        r_buzzer   <= w_phase_nx & ~r_ring_cnt[0];
                     end
                  end
               end
               S_SNOOZE: begin
                  if (btn[3]) begin
                     r_state <= S_IDLE;
                  end else if (sec_pulse) begin
                     if (w_snooze_inc == LP_SNOOZE_END) begin
                        r_state    <= S_RING;
                        r_ringing  <= 1'b1;
                        r_ring_cnt <= '0;
                     end else begin
                        r_snooze_cnt <= w_snooze_inc;
                     end
                  end
               end
               default: begin
                  r_state   <= S_IDLE;
                  r_ringing <= 1'b0;
               end
            endcase
         end
      end
   end

   assign alarm_bcd = {r_hh, r_mm};
   assign armed     = r_armed;
   assign state     = r_state;
   assign ringing   = r_ringing;
   assign buzzer    = r_buzzer;

endmodule

// File: tb/tb_alarm_unit.sv
// tb/tb_alarm_unit.sv - randomized bench for alarm_unit against a time-level model.
module tb_alarm_unit;

   localparam int RS = 60;
   localparam int SM = 5;
   localparam int TD = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        sec_pulse = 1'b0;
   logic [23:0] time_bcd = 24'h0;
   logic        set_mode = 1'b0;
   logic [3:0]  btn = 4'h0;
   logic [15:0] alarm_bcd;
   logic        armed;
   logic [1:0]  state;
   logic        ringing;
   logic        buzzer;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: alarm as integer hour/minute, elapsed ring seconds/cycles, snooze seconds.
   int m_hh, m_mm, m_armed, m_state, m_rsec, m_rcyc, m_snz;
   logic r_sm = 1'b0;

   alarm_unit #(.RING_SECS(RS), .SNOOZE_MIN(SM), .TONE_DIV(TD)) dut (
      .clk(clk), .rst(rst), .sec_pulse(sec_pulse), .time_bcd(time_bcd),
      .set_mode(set_mode), .btn(btn), .alarm_bcd(alarm_bcd), .armed(armed),
      .state(state), .ringing(ringing), .buzzer(buzzer)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] to_bcd(input int v);
      return 8'(((v / 10) << 4) + (v % 10));
   endfunction

   function automatic logic [23:0] alarm_time();
      return {to_bcd(m_hh), to_bcd(m_mm), 8'h00};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick(input logic r, input logic s, input logic [23:0] t,
                       input logic sm, input logic [3:0] b);
      logic match;
      logic exp_buz;
      rst = r; sec_pulse = s; time_bcd = t; set_mode = sm; btn = b;
      @(posedge clk);
      if (r) begin
         m_hh = 7; m_mm = 0; m_armed = 0; m_state = 0; m_rsec = 0; m_rcyc = 0; m_snz = 0;
      end else begin
         match = s && (m_armed != 0) && !sm && m_state == 0 && t == alarm_time();
         if (sm) begin
            if (b[0]) m_hh = (m_hh + 1) % 24;
            if (b[1]) m_mm = (m_mm + 1) % 60;
         end
         if (m_state == 0 && b[3]) m_armed = 1 - m_armed;
         if (sm) m_state = 0;
         else if (m_state == 1) begin
            if (b[3]) m_state = 0;
            else if (b[2]) begin m_state = 2; m_snz = 0; end
            else begin
               m_rcyc++;
               if (s) begin
                  m_rsec++;
                  if (m_rsec == RS) m_state = 0;
               end
            end
         end else if (m_state == 2) begin
            if (b[3]) m_state = 0;
            else if (s) begin
               m_snz++;
               if (m_snz == SM * 60) begin m_state = 1; m_rsec = 0; m_rcyc = 0; end
            end
         end else if (!b[3] && match) begin
            m_state = 1; m_rsec = 0; m_rcyc = 0;
         end
      end
      #1;
      exp_buz = (m_state == 1) && (((m_rcyc / TD) % 2) == 1) && ((m_rsec % 2) == 0);
      check("alarm_bcd", 32'(alarm_bcd), 32'({to_bcd(m_hh), to_bcd(m_mm)}));
      check("armed", 32'(armed), 32'(m_armed));
      check("state", 32'(state), 32'(m_state));
      check("ringing", 32'(ringing), 32'(m_state == 1));
      check("buzzer", 32'(buzzer), 32'(exp_buz));
   endtask

   task automatic idle(input int n, input logic [23:0] t, input logic sm);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, t, sm, 4'h0);
   endtask

   task automatic secs(input int n, input logic [23:0] t);
      for (int i = 0; i < n; i++) begin
         idle($urandom_range(2, 9), t, 1'b0);
         tick(1'b0, 1'b1, t, 1'b0, ($urandom_range(0, 3) == 0 && m_state == 2) ? 4'b0100 : 4'h0);
      end
   endtask

   initial begin
      tick(1'b1, 1'b0, 24'h0, 1'b0, 4'h0);
      tick(1'b1, 1'b0, 24'h0, 1'b0, 4'h0);
      check("reset_bcd", 32'(alarm_bcd), 32'h0700);
      check("reset_state", 32'(state), 32'h0);

      for (int i = 0; i < 17; i++) begin
         tick(1'b0, 1'b0, 24'h0, 1'b1, 4'b0001);
         idle($urandom_range(0, 2), 24'h0, 1'b1);
      end
      for (int i = 0; i < 61; i++) begin
         tick(1'b0, 1'b0, 24'h0, 1'b1, 4'b0010);
         idle($urandom_range(0, 2), 24'h0, 1'b1);
      end
      check("edit_bcd", 32'(alarm_bcd), 32'h0001);

      tick(1'b1, 1'b0, 24'h0, 1'b0, 4'h0);
      tick(1'b0, 1'b0, 24'h0, 1'b0, 4'b1000);
      check("arm", 32'(armed), 32'h1);

      tick(1'b0, 1'b1, 24'h070000, 1'b0, 4'h0);
      check("ring_entry", 32'(state), 32'h1);
      secs(RS - 1, 24'h070000);
      check("ring_59", 32'(state), 32'h1);
      secs(1, 24'h070000);
      check("auto_stop", 32'(state), 32'h0);
      idle(5, 24'h070100, 1'b0);

      tick(1'b0, 1'b1, 24'h070000, 1'b0, 4'h0);
      secs(3, 24'h070000);
      tick(1'b0, 1'b0, 24'h070000, 1'b0, 4'b0100);
      check("snooze", 32'(state), 32'h2);
      secs(SM * 60 - 1, 24'h070000);
      check("snooze_299", 32'(state), 32'h2);
      secs(1, 24'h070000);
      check("snooze_exp", 32'(state), 32'h1);
      idle(6, 24'h070000, 1'b0);
      tick(1'b0, 1'b0, 24'h070000, 1'b0, 4'b1000);
      check("stop", 32'(state), 32'h0);
      check("stop_armed", 32'(armed), 32'h1);
      idle(3, 24'h070100, 1'b0);

      tick(1'b0, 1'b1, 24'h070000, 1'b0, 4'h0);
      idle(3, 24'h070000, 1'b0);
      tick(1'b0, 1'b0, 24'h070000, 1'b0, 4'b1100);
      check("prio_b3_b2", 32'(state), 32'h0);
      tick(1'b0, 1'b1, 24'h070000, 1'b0, 4'h0);
      secs(2, 24'h070000);
      tick(1'b0, 1'b1, 24'h070000, 1'b0, 4'b1000);
      check("prio_b3_sec", 32'(state), 32'h0);
      check("prio_armed", 32'(armed), 32'h1);

      tick(1'b0, 1'b1, 24'h070000, 1'b1, 4'h0);
      check("supp_setmode", 32'(state), 32'h0);
      tick(1'b0, 1'b1, 24'h070001, 1'b0, 4'h0);
      check("supp_ss", 32'(state), 32'h0);
      tick(1'b0, 1'b0, 24'h070000, 1'b0, 4'b1000);
      tick(1'b0, 1'b1, 24'h070000, 1'b0, 4'h0);
      check("supp_unarmed", 32'(state), 32'h0);
      tick(1'b0, 1'b0, 24'h070000, 1'b0, 4'b1000);
      tick(1'b0, 1'b1, 24'h070000, 1'b0, 4'h0);
      tick(1'b0, 1'b0, 24'h070000, 1'b0, 4'b0100);
      secs(4, 24'h070000);
      tick(1'b0, 1'b0, 24'h070000, 1'b1, 4'h0);
      check("supp_snooze_set", 32'(state), 32'h0);
      tick(1'b0, 1'b0, 24'h070100, 1'b0, 4'h0);

      for (int i = 0; i < 3000; i++) begin
         logic [23:0] t;
         logic [3:0]  b;
         if ($urandom_range(0, 49) == 0) r_sm = ~r_sm;
         case ($urandom_range(0, 3))
            0, 1: t = alarm_time();
            2:    t = alarm_time() | 24'h000001;
            default: t = 24'($urandom);
         endcase
         b = 4'h0;
         for (int k = 0; k < 4; k++) b[k] = ($urandom_range(0, 9) == 0);
         tick($urandom_range(0, 299) == 0, $urandom_range(0, 3) == 0, t, r_sm, b);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
